// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//
// Conditions the four raw direction buttons for the snake engine:
// - two-flop synchronizer per button;
// - counter-based debounce;
// - one-cycle press pulses;
// - a pending-turn register that is committed to the heading on each
//   game tick, with 180-degree reversals rejected.
//
// Bit order everywhere is 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
// Heading encoding is 00=UP, 01=RIGHT, 10=DOWN, 11=LEFT.

module snake_dir_ctrl #(
    parameter int         DB_CYCLES = 4,
    parameter int         CNT_W     = $clog2(DB_CYCLES),
    parameter logic [1:0] RESET_DIR = 2'b01
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] btn_raw,
    input  logic       run,
    input  logic       game_tick,
    output logic [3:0] btn_pulse,
    output logic [1:0] dir,
    output logic [1:0] dir_pending,
    output logic       dir_changed
);

    // Counter terminal value and increment, sized to the counter width.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Lowest set bit wins, which gives the UP > RIGHT > DOWN > LEFT priority.
    function automatic logic [1:0] select_req(input logic [3:0] pulses);
        logic [1:0] sel;
        if (pulses[0]) begin
            sel = 2'b00;
        end else if (pulses[1]) begin
            sel = 2'b01;
        end else if (pulses[2]) begin
            sel = 2'b10;
        end else begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    // Opposite headings differ only in the upper encoding bit.
    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] heading);
        return (req == (heading ^ 2'b10));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       stable_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [3:0]       btn_pulse_r;
    logic [1:0]       dir_r;
    logic [1:0]       dir_pending_r;
    logic             dir_changed_r;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [3:0]       stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s [4];
    logic [3:0]       pulse_nxt_s;

    logic [1:0]       req_s;
    logic             req_valid_s;
    logic [1:0]       ref_dir_s;
    logic             accept_s;
    logic             commit_s;
    logic [1:0]       dir_nxt_s;
    logic [1:0]       dir_pending_nxt_s;
    logic             dir_changed_nxt_s;

    // Two-flop synchronizer; btn_raw is asynchronous to Clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a disagreement must persist DB_CYCLES consecutive cycles before
    // the stable value flips. A rising flip also raises the press pulse.
    always_comb begin
        stable_nxt_s = stable_r;
        pulse_nxt_s  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
                stable_nxt_s[i] = sync2_r[i];
                pulse_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i]    = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state and registered press pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stable_r    <= 4'b0000;
            btn_pulse_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            stable_r    <= stable_nxt_s;
            btn_pulse_r <= pulse_nxt_s;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Direction control.
    // - A request is checked against the heading that will be current after
    //   this edge: the pending value when a tick commits it, otherwise the
    //   present heading.
    // - Ticks and requests are ignored while the game is not running.
    always_comb begin
        req_s             = select_req(btn_pulse_r);
        req_valid_s       = |btn_pulse_r;
        commit_s          = run && game_tick;
        ref_dir_s         = dir_r;
        accept_s          = 1'b0;
        dir_nxt_s         = dir_r;
        dir_pending_nxt_s = dir_pending_r;
        dir_changed_nxt_s = 1'b0;

        if (game_tick) begin
            ref_dir_s = dir_pending_r;
        end else begin
            ref_dir_s = dir_r;
        end

        if (run && req_valid_s && !is_reverse(req_s, ref_dir_s)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        if (accept_s) begin
            dir_pending_nxt_s = req_s;
        end else begin
            dir_pending_nxt_s = dir_pending_r;
        end

        if (commit_s) begin
            dir_nxt_s         = dir_pending_r;
            dir_changed_nxt_s = (dir_pending_r != dir_r);
        end else begin
            dir_nxt_s         = dir_r;
            dir_changed_nxt_s = 1'b0;
        end
    end

    // Heading, pending turn and change strobe registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_r         <= RESET_DIR;
            dir_pending_r <= RESET_DIR;
            dir_changed_r <= 1'b0;
        end else begin
            dir_r         <= dir_nxt_s;
            dir_pending_r <= dir_pending_nxt_s;
            dir_changed_r <= dir_changed_nxt_s;
        end
    end

    assign btn_pulse   = btn_pulse_r;
    assign dir         = dir_r;
    assign dir_pending = dir_pending_r;
    assign dir_changed = dir_changed_r;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Testbench for snake_dir_ctrl.
//
// The reference model keeps the full history of sampled button values.
// A stable value flips when the last DB synchronized samples (taken two
// edges late) all disagree with it. Heading rules are applied with plain
// arithmetic.

module tb_snake_dir_ctrl;

    localparam int DB = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] btn_raw;
    logic       run;
    logic       game_tick;
    logic [3:0] btn_pulse;
    logic [1:0] dir;
    logic [1:0] dir_pending;
    logic       dir_changed;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [3:0] hist [0:8191];
    int         e;
    logic [3:0] m_stable;
    logic [3:0] m_pulse;
    logic [1:0] m_dir;
    logic [1:0] m_pend;
    logic       m_chg;

    snake_dir_ctrl #(.DB_CYCLES(DB)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .btn_raw    (btn_raw),
        .run        (run),
        .game_tick  (game_tick),
        .btn_pulse  (btn_pulse),
        .dir        (dir),
        .dir_pending(dir_pending),
        .dir_changed(dir_changed)
    );

    // 100 MHz clock.
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_edge(input logic rst, input logic [3:0] raw,
                              input logic r, input logic t);
        logic [3:0] ns;
        logic [3:0] np;
        logic [3:0] smp;
        logic [1:0] req;
        logic [1:0] refd;
        logic       all_diff;
        e++;
        if (rst) begin
            hist[e]     = 4'h0;
            hist[e-1]   = 4'h0;
            m_stable    = 4'h0;
            m_pulse     = 4'h0;
            m_dir       = 2'b01;
            m_pend      = 2'b01;
            m_chg       = 1'b0;
        end else begin
            hist[e] = raw;
            // Direction rules use the pulses visible before this edge.
            if (m_pulse[0]) req = 2'd0;
            else if (m_pulse[1]) req = 2'd1;
            else if (m_pulse[2]) req = 2'd2;
            else req = 2'd3;
            refd = t ? m_pend : m_dir;
            m_chg = 1'b0;
            if (r && t) begin
                m_chg = (m_pend != m_dir);
                m_dir = m_pend;
            end
            if (r && (m_pulse != 4'h0) && (req != (refd ^ 2'b10))) begin
                m_pend = req;
            end
            // Debounce over a window of synchronized samples.
            ns = m_stable;
            np = 4'h0;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    smp = hist[e-2-k];
                    if (smp[i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    ns[i] = ~m_stable[i];
                    np[i] = ~m_stable[i];
                end
            end
            m_stable = ns;
            m_pulse  = np;
        end
    endtask

    // Drive one cycle, update the model on the edge, compare on the falling edge.
    task automatic step(input logic rst, input logic [3:0] raw,
                        input logic r, input logic t);
        Reset     = rst;
        btn_raw   = raw;
        run       = r;
        game_tick = t;
        @(posedge Clk);
        model_edge(rst, raw, r, t);
        @(negedge Clk);
        check("btn_pulse", btn_pulse, m_pulse);
        check("dir", {2'b00, dir}, {2'b00, m_dir});
        check("dir_pending", {2'b00, dir_pending}, {2'b00, m_pend});
        check("dir_changed", {3'b000, dir_changed}, {3'b000, m_chg});
    endtask

    // Hold a button mask for n_hi cycles, then release for n_lo cycles.
    task automatic press(input logic [3:0] mask, input int n_hi, input int n_lo, input logic r);
        for (int i = 0; i < n_hi; i++) step(1'b0, mask, r, 1'b0);
        for (int i = 0; i < n_lo; i++) step(1'b0, 4'h0, r, 1'b0);
    endtask

    initial begin
        logic [3:0] rraw;
        for (int i = 0; i < 8192; i++) hist[i] = 4'h0;
        e         = 8;
        m_stable  = 4'h0;
        m_pulse   = 4'h0;
        m_dir     = 2'b01;
        m_pend    = 2'b01;
        m_chg     = 1'b0;
        Reset     = 1'b1;
        btn_raw   = 4'h0;
        run       = 1'b0;
        game_tick = 1'b0;
        @(negedge Clk);

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 1'b0, 1'b0);
        check("rst_dir", {2'b00, dir}, 4'h1);
        check("rst_pending", {2'b00, dir_pending}, 4'h1);
        check("rst_pulse", btn_pulse, 4'h0);
        check("rst_changed", {3'b000, dir_changed}, 4'h0);

        // UP held 20 cycles: single pulse after the sixth edge.
        for (int i = 0; i < 5; i++) step(1'b0, 4'h1, 1'b1, 1'b0);
        check("up_no_early_pulse", btn_pulse, 4'h0);
        step(1'b0, 4'h1, 1'b1, 1'b0);
        check("up_pulse", btn_pulse, 4'h1);
        step(1'b0, 4'h1, 1'b1, 1'b0);
        check("up_pulse_once", btn_pulse, 4'h0);
        check("up_pending", {2'b00, dir_pending}, 4'h0);
        press(4'h1, 13, 10, 1'b1);

        // DOWN with bounce, then held.
        for (int j = 0; j < 3; j++) press(4'h4, 3, 3, 1'b1);
        press(4'h4, 10, 8, 1'b1);
        check("down_pending", {2'b00, dir_pending}, 4'h2);

        // RIGHT then LEFT: LEFT rejected; tick keeps dir at RIGHT.
        press(4'h2, 8, 8, 1'b1);
        press(4'h8, 8, 8, 1'b1);
        check("left_rejected", {2'b00, dir_pending}, 4'h1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        check("tick_same_dir", {2'b00, dir}, 4'h1);
        check("tick_no_change", {3'b000, dir_changed}, 4'h0);

        // UP then DOWN before the tick: last wins.
        press(4'h1, 8, 8, 1'b1);
        press(4'h4, 8, 8, 1'b1);
        check("last_wins", {2'b00, dir_pending}, 4'h2);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        check("commit_down", {2'b00, dir}, 4'h2);
        check("commit_strobe", {3'b000, dir_changed}, 4'h1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("strobe_one_cycle", {3'b000, dir_changed}, 4'h0);

        // Back to dir=RIGHT, pending=UP, then LEFT pulse coincident with tick.
        press(4'h2, 8, 8, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        press(4'h1, 8, 8, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h8, 1'b1, 1'b0);
        step(1'b0, 4'h8, 1'b1, 1'b1);
        check("same_cycle_dir", {2'b00, dir}, 4'h0);
        check("same_cycle_pending", {2'b00, dir_pending}, 4'h3);
        check("same_cycle_changed", {3'b000, dir_changed}, 4'h1);
        press(4'h8, 4, 8, 1'b1);

        // Same setup with run low: state held, pulse still fires.
        press(4'h2, 8, 8, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        press(4'h1, 8, 8, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h8, 1'b0, 1'b0);
        check("run0_pulse", btn_pulse, 4'h8);
        step(1'b0, 4'h8, 1'b0, 1'b1);
        check("run0_dir", {2'b00, dir}, 4'h1);
        check("run0_pending", {2'b00, dir_pending}, 4'h0);
        check("run0_changed", {3'b000, dir_changed}, 4'h0);
        press(4'h8, 4, 8, 1'b0);

        // Reset mid-debounce, button still held afterwards.
        press(4'h2, 2, 0, 1'b1);
        step(1'b1, 4'h2, 1'b1, 1'b0);
        press(4'h2, 10, 6, 1'b1);

        // Randomized phase.
        rraw = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rraw[b] = ~rraw[b];
            end
            step(($urandom_range(0, 299) == 0), rraw,
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
